// File: rtl/mif_pkg.sv
// Shared MCB instruction codes, credit limit and scheduler state encodings.
package mif_pkg;

  localparam logic [2:0] MCB_INSTR_WR = 3'b000;
  localparam logic [2:0] MCB_INSTR_RD = 3'b001;

  // Depth of the MCB read data FIFO in 64-bit words.
  localparam logic [6:0] CREDIT_MAX = 7'd64;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_RUN   = 2'd1,
    R_DRAIN = 2'd2
  } rstate_t;

  typedef enum logic {
    W_FILL = 1'b0,
    W_CMD  = 1'b1
  } wstate_t;

endpackage

// File: rtl/mif_wr_sched.sv
// Write-side scheduler: gathers pixel words into MCB bursts and issues
// p1 write commands, with partial-burst flush on frame start.
module mif_wr_sched
  import mif_pkg::*;
#(
  parameter logic [29:0] FB_BASE  = 30'h0,
  parameter logic [23:0] FB_WORDS = 24'd196608,
  parameter int          BURST    = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_calib,
  input  logic        i_vsync_rise,
  input  logic [63:0] i_pix_write,
  input  logic        i_pix_write_valid,
  output logic        o_pix_write_ready,
  output logic        o_cmd_en,
  output logic [2:0]  o_cmd_instr,
  output logic [5:0]  o_cmd_bl,
  output logic [29:0] o_cmd_byte_addr,
  input  logic        i_cmd_full,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_mask,
  output logic [63:0] o_wr_data,
  input  logic        i_wr_full,
  output logic        o_state
);

  wstate_t     r_state, w_state_nxt;
  logic        r_run;
  logic [5:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [5:0]  r_bl, w_bl_nxt;
  logic [29:0] r_addr, w_addr_nxt;
  logic [23:0] r_frame, w_frame_nxt;
  logic        r_flush, w_flush_nxt;

  // r_run keeps the write port quiet while reset is asserted.
  assign o_pix_write_ready = r_run && i_calib && !i_wr_full && (r_state == W_FILL);
  assign o_wr_en           = i_pix_write_valid && o_pix_write_ready;
  assign o_wr_data         = i_pix_write;
  assign o_wr_mask         = 8'h00;
  assign o_cmd_instr       = MCB_INSTR_WR;
  assign o_cmd_bl          = r_bl;
  assign o_cmd_byte_addr   = r_addr;
  assign o_state           = r_state;
  assign w_cnt_inc         = r_cnt + {5'd0, o_wr_en};

  // State and burst bookkeeping registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= W_FILL;
      r_run   <= 1'b0;
      r_cnt   <= 6'd0;
      r_bl    <= 6'(BURST - 1);
      r_addr  <= FB_BASE;
      r_frame <= 24'd0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_bl    <= w_bl_nxt;
      r_addr  <= w_addr_nxt;
      r_frame <= w_frame_nxt;
      r_flush <= w_flush_nxt;
    end
  end

  // Next-state: fill a burst (or flush on vsync), then issue its command.
  // r_flush means the address returns to FB_BASE once the command is out.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bl_nxt    = r_bl;
    w_addr_nxt  = r_addr;
    w_frame_nxt = r_frame;
    w_flush_nxt = r_flush;
    o_cmd_en    = 1'b0;
    case (r_state)
      W_FILL: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_inc == 6'(BURST)) begin
          w_state_nxt = W_CMD;
          w_bl_nxt    = 6'(BURST - 1);
          w_cnt_nxt   = 6'd0;
          w_flush_nxt = i_vsync_rise;
        end else if (i_vsync_rise) begin
          if (w_cnt_inc != 6'd0) begin
            w_state_nxt = W_CMD;
            w_bl_nxt    = w_cnt_inc - 6'd1;
            w_cnt_nxt   = 6'd0;
            w_flush_nxt = 1'b1;
          end else begin
            w_addr_nxt  = FB_BASE;
            w_frame_nxt = 24'd0;
          end
        end
      end
      W_CMD: begin
        if (i_vsync_rise) w_flush_nxt = 1'b1;
        if (i_calib && !i_cmd_full) begin
          o_cmd_en    = 1'b1;
          w_state_nxt = W_FILL;
          if (r_flush || i_vsync_rise ||
              ({1'b0, r_frame} + 25'(BURST) >= {1'b0, FB_WORDS})) begin
            w_addr_nxt  = FB_BASE;
            w_frame_nxt = 24'd0;
            w_flush_nxt = 1'b0;
          end else begin
            w_addr_nxt  = r_addr + 30'(BURST * 8);
            w_frame_nxt = r_frame + 24'(BURST);
          end
        end
      end
      default: w_state_nxt = W_FILL;
    endcase
  end

endmodule

// File: rtl/mif_sched.sv
// Framebuffer scheduler between the pixel streams and two MCB user ports.
// valid/ready: a word transfers on a clk_mif rising edge where valid and
// ready are both high; the source holds valid and data until that edge.
module mif_sched
  import mif_pkg::*;
#(
  parameter logic [29:0] FB_BASE  = 30'h0,
  parameter logic [23:0] FB_WORDS = 24'd196608,
  parameter int          BURST    = 32
) (
  input  logic        clk_mif,
  input  logic        rst_n,
  input  logic        ddr_calib_done,
  input  logic        vsync,
  output logic [63:0] pix_read,
  output logic        pix_read_valid,
  input  logic        pix_read_ready,
  input  logic [63:0] pix_write,
  input  logic        pix_write_valid,
  output logic        pix_write_ready,
  output logic        p0_cmd_en,
  output logic [2:0]  p0_cmd_instr,
  output logic [5:0]  p0_cmd_bl,
  output logic [29:0] p0_cmd_byte_addr,
  input  logic        p0_cmd_full,
  output logic        p0_rd_en,
  input  logic [63:0] p0_rd_data,
  input  logic        p0_rd_empty,
  output logic        p1_cmd_en,
  output logic [2:0]  p1_cmd_instr,
  output logic [5:0]  p1_cmd_bl,
  output logic [29:0] p1_cmd_byte_addr,
  input  logic        p1_cmd_full,
  output logic        p1_wr_en,
  output logic [7:0]  p1_wr_mask,
  output logic [63:0] p1_wr_data,
  input  logic        p1_wr_full,
  output logic [1:0]  o_dbg_rstate,
  output logic        o_dbg_wstate
);

  rstate_t     r_rstate, w_rstate_nxt;
  logic        r_vsync_d;
  logic        w_vsync_rise;
  logic [6:0]  r_credit, w_credit_nxt;
  logic [29:0] r_rd_addr, w_rd_addr_nxt;
  logic [23:0] r_rd_left, w_rd_left_nxt;

  assign w_vsync_rise     = vsync && !r_vsync_d;
  assign pix_read         = p0_rd_data;
  assign pix_read_valid   = ddr_calib_done && !p0_rd_empty && (r_rstate == R_RUN);
  assign p0_rd_en         = ddr_calib_done &&
                            ((pix_read_valid && pix_read_ready) ||
                             ((r_rstate == R_DRAIN) && !p0_rd_empty));
  assign p0_cmd_instr     = MCB_INSTR_RD;
  assign p0_cmd_bl        = 6'(BURST - 1);
  assign p0_cmd_byte_addr = r_rd_addr;
  assign o_dbg_rstate     = r_rstate;

  // Read state, FIFO credit, address and remaining-word registers.
  always_ff @(posedge clk_mif or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_vsync_d <= 1'b0;
      r_credit  <= CREDIT_MAX;
      r_rd_addr <= FB_BASE;
      r_rd_left <= 24'd0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_vsync_d <= vsync;
      r_credit  <= w_credit_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_rd_left <= w_rd_left_nxt;
    end
  end

  // Read next-state: prefetch bursts while the FIFO has room; on a new frame
  // with words still in flight, discard them before restarting at FB_BASE.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_rd_addr_nxt = r_rd_addr;
    w_rd_left_nxt = r_rd_left;
    p0_cmd_en     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (ddr_calib_done && w_vsync_rise) begin
          w_rstate_nxt  = R_RUN;
          w_rd_addr_nxt = FB_BASE;
          w_rd_left_nxt = FB_WORDS;
        end
      end
      R_RUN: begin
        if (ddr_calib_done && w_vsync_rise) begin
          if (r_credit == CREDIT_MAX) begin
            w_rd_addr_nxt = FB_BASE;
            w_rd_left_nxt = FB_WORDS;
          end else begin
            w_rstate_nxt = R_DRAIN;
          end
        end else if (ddr_calib_done && (r_credit >= 7'(BURST)) &&
                     !p0_cmd_full && (r_rd_left != 24'd0)) begin
          p0_cmd_en     = 1'b1;
          w_rd_addr_nxt = r_rd_addr + 30'(BURST * 8);
          w_rd_left_nxt = r_rd_left - 24'(BURST);
        end
      end
      R_DRAIN: begin
        if (r_credit == CREDIT_MAX) begin
          w_rstate_nxt  = R_RUN;
          w_rd_addr_nxt = FB_BASE;
          w_rd_left_nxt = FB_WORDS;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
    w_credit_nxt = r_credit - (p0_cmd_en ? 7'(BURST) : 7'd0) + {6'd0, p0_rd_en};
  end

  mif_wr_sched #(
    .FB_BASE  (FB_BASE),
    .FB_WORDS (FB_WORDS),
    .BURST    (BURST)
  ) u_wr_sched (
    .i_clk             (clk_mif),
    .i_rst_n           (rst_n),
    .i_calib           (ddr_calib_done),
    .i_vsync_rise      (w_vsync_rise),
    .i_pix_write       (pix_write),
    .i_pix_write_valid (pix_write_valid),
    .o_pix_write_ready (pix_write_ready),
    .o_cmd_en          (p1_cmd_en),
    .o_cmd_instr       (p1_cmd_instr),
    .o_cmd_bl          (p1_cmd_bl),
    .o_cmd_byte_addr   (p1_cmd_byte_addr),
    .i_cmd_full        (p1_cmd_full),
    .o_wr_en           (p1_wr_en),
    .o_wr_mask         (p1_wr_mask),
    .o_wr_data         (p1_wr_data),
    .i_wr_full         (p1_wr_full),
    .o_state           (o_dbg_wstate)
  );

endmodule
